// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encoding, FSM state encoding and op-class decode helpers.
package muldiv_pkg;

    // Op encoding; Op[0] selects signed arithmetic
    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MADDU = 3'b100;
    localparam logic [2:0] OP_MADD  = 3'b101;
    localparam logic [2:0] OP_MSUBU = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    // Plain multiply (MULT/MULTU)
    function automatic logic op_is_mult(input logic [2:0] op);
        return op[2:1] == 2'b00;
    endfunction

    // Divide (DIV/DIVU)
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

    // Multiply-accumulate family (MADD/MADDU/MSUB/MSUBU)
    function automatic logic op_is_macc(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, compare against the divisor and subtract when it fits.
// Ports:
//   rem_in  / rem_out : partial remainder before / after the step
//   quo_in  / quo_out : dividend bits still to shift out (MSB first), with
//                       quotient bits shifted in at the LSB
//   divisor           : magnitude of the divisor
module muldiv_divstep
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic           fits;

    // Remainder stays below the divisor, so WIDTH+1 bits hold the shifted value
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        fits    = shifted >= {1'b0, divisor};
        if (fits) begin
            rem_out = WIDTH'(shifted - {1'b0, divisor});
        end else begin
            rem_out = shifted[WIDTH-1:0];
        end
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Multiplies complete after MULT_CYCLES cycles; divides use a bit-serial
// restoring divider taking WIDTH+2 cycles (setup, WIDTH steps, sign fixup).
// Optional multiply-accumulate ops are enabled by defining MULTDIV_MACC_EN;
// without it, Op 1xx is a no-op (Start ignored).
// Ports:
//   Clk, Rst    : clock (rising edge), asynchronous active-low reset
//   D1, D2      : operand A / dividend / HI-LO write data, operand B / divisor
//   Op, Start   : operation and launch strobe (accepted only when idle)
//   We, HiLo    : write D1 into HI (HiLo=1) or LO (HiLo=0) when idle
//   Busy        : operation in progress
//   Done        : one-cycle pulse when HI/LO were updated by an operation
//   HI, LO      : result registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [2:0]       Op,
    input  logic             Start,
    input  logic             We,
    input  logic             HiLo,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned W2      = 2 * WIDTH;
    localparam int unsigned LAT_DIV = WIDTH + 2;
    localparam int unsigned LAT_MAX = (LAT_DIV > MULT_CYCLES) ? LAT_DIV : MULT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    logic             mul_class;
    logic             start_mul;
    logic             start_div;

    logic [W2-1:0]    ext_a;
    logic [W2-1:0]    ext_b;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    mul_res;
    logic [W2-1:0]    mul_acc;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic             a_neg;
    logic             b_neg;
    logic             dz;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // Op-class decode; accumulate ops only launch when the feature is built in
`ifdef MULTDIV_MACC_EN
    assign mul_class = op_is_mult(Op) || op_is_macc(Op);
`else
    assign mul_class = op_is_mult(Op);
`endif

    assign start_mul = (state == ST_IDLE) && Start && mul_class;
    assign start_div = (state == ST_IDLE) && Start && op_is_div(Op);
    assign cnt_zero  = (cnt == '0);

    // Full-width product of the extended operands; low 2*WIDTH bits are exact
    // for both signed and unsigned operands
    always_comb begin
        ext_a = Op[0] ? {{WIDTH{D1[WIDTH-1]}}, D1} : {{WIDTH{1'b0}}, D1};
        ext_b = Op[0] ? {{WIDTH{D2[WIDTH-1]}}, D2} : {{WIDTH{1'b0}}, D2};
        prod  = W2'(ext_a * ext_b);
    end

    // Result captured at launch; an accumulate sees a same-cycle We write first
`ifdef MULTDIV_MACC_EN
    logic [W2-1:0] hilo_base;

    always_comb begin
        hilo_base = {HI, LO};
        if (We) begin
            if (HiLo) begin
                hilo_base[W2-1:WIDTH] = D1;
            end else begin
                hilo_base[WIDTH-1:0] = D1;
            end
        end
        if (!op_is_macc(Op)) begin
            mul_res = prod;
        end else if (Op[1]) begin
            mul_res = hilo_base - prod;
        end else begin
            mul_res = hilo_base + prod;
        end
    end
`else
    assign mul_res = prod;
`endif

    muldiv_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    // State register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start_mul) begin
                    next_state = ST_MUL;
                end else if (start_div) begin
                    next_state = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_zero) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath, counter and registered outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            mul_acc <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            a_neg   <= 1'b0;
            b_neg   <= 1'b0;
            dz      <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (We) begin
                        if (HiLo) begin
                            HI <= D1;
                        end else begin
                            LO <= D1;
                        end
                    end
                    if (start_mul) begin
                        mul_acc <= mul_res;
                        cnt     <= CNT_W'(MULT_CYCLES - 1);
                        Busy    <= 1'b1;
                    end else if (start_div) begin
                        a_q   <= D1;
                        b_q   <= D2;
                        sgn_q <= Op[0];
                        cnt   <= CNT_W'(LAT_DIV - 1);
                        Busy  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (cnt_zero) begin
                        HI   <= mul_acc[W2-1:WIDTH];
                        LO   <= mul_acc[WIDTH-1:0];
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV: begin
                    if (cnt == CNT_W'(WIDTH + 1)) begin
                        // Setup: operand magnitudes and divide-by-zero flag
                        a_neg <= sgn_q & a_q[WIDTH-1];
                        b_neg <= sgn_q & b_q[WIDTH-1];
                        quo_q <= (sgn_q & a_q[WIDTH-1]) ? -a_q : a_q;
                        dvs_q <= (sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
                        rem_q <= '0;
                        dz    <= (b_q == '0);
                        cnt   <= cnt - 1'b1;
                    end else if (!cnt_zero) begin
                        rem_q <= rem_nx;
                        quo_q <= quo_nx;
                        cnt   <= cnt - 1'b1;
                    end else begin
                        // Sign fixup; MIN/-1 naturally wraps to MIN with remainder 0
                        if (dz) begin
                            LO <= '1;
                            HI <= a_q;
                        end else begin
                            LO <= (a_neg ^ b_neg) ? -quo_q : quo_q;
                            HI <= a_neg ? -rem_q : rem_q;
                        end
                        Busy <= 1'b0;
                        Done <= 1'b1;
                    end
                end
                default: begin
                    Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
